// File: rtl/imem_loader_pkg.sv
// Shared constants and state encoding for the boot-time instruction memory loader.
package imem_loader_pkg;

  localparam int INST_W = 32;
  localparam int CNT_W  = 16;
  localparam int CSUM_W = 8;

  typedef enum logic [2:0] {
    ST_CNT_LO = 3'd0,
    ST_CNT_HI = 3'd1,
    ST_DATA   = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
  } ld_state_e;

endpackage

// File: rtl/imem_loader_word_packer.sv
// Packs a byte stream little-endian into instruction words; emits a registered word and one-cycle strobe.
module word_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              byte_stb_i,
  input  logic [7:0]        byte_i,
  output logic              last_lane_o,
  output logic [INST_W-1:0] word_o,
  output logic              word_stb_o
);

  logic [1:0]        lane_q, lane_d;
  logic [23:0]       shift_q, shift_d;
  logic [INST_W-1:0] word_q, word_d;
  logic              stb_q, stb_d;

  assign last_lane_o = (lane_q == 2'd3);
  assign word_o      = word_q;
  assign word_stb_o  = stb_q;

  always_comb begin
    lane_d  = lane_q;
    shift_d = shift_q;
    word_d  = word_q;
    stb_d   = 1'b0;
    if (clr_i) begin
      lane_d  = 2'd0;
      shift_d = '0;
    end else if (byte_stb_i) begin
      if (lane_q == 2'd3) begin
        word_d = {byte_i, shift_q};
        stb_d  = 1'b1;
        lane_d = 2'd0;
      end else begin
        // New byte enters at the top so the first byte ends up in bits [7:0].
        shift_d = {byte_i, shift_q[23:8]};
        lane_d  = lane_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane_q  <= 2'd0;
      shift_q <= '0;
      word_q  <= '0;
      stb_q   <= 1'b0;
    end else begin
      lane_q  <= lane_d;
      shift_q <= shift_d;
      word_q  <= word_d;
      stb_q   <= stb_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: count header, packed instruction words, XOR checksum; releases the core only on a clean load.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  input  logic              reload,
  output logic              imem_wena,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [INST_W-1:0] imem_wdata,
  output logic              core_rst_n,
  output logic              load_done,
  output logic              load_err
);

  localparam logic [CNT_W-1:0] DEPTH_N = CNT_W'(DEPTH);

  ld_state_e         state_q, state_d;
  logic [CNT_W-1:0]  n_q, n_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [CSUM_W-1:0] csum_q, csum_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic              byte_ready_q, load_done_q, load_err_q, core_rst_n_q;

  logic              accept;
  logic [CNT_W-1:0]  n_full;
  logic [ADDR_W:0]   idx_inc;
  logic              pk_clr, pk_stb, pk_last;

  assign accept  = byte_valid && byte_ready_q;
  assign n_full  = {byte_data, n_q[7:0]};
  assign idx_inc = idx_q + {{ADDR_W{1'b0}}, 1'b1};

  word_packer u_packer (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (pk_clr),
    .byte_stb_i  (pk_stb),
    .byte_i      (byte_data),
    .last_lane_o (pk_last),
    .word_o      (imem_wdata),
    .word_stb_o  (imem_wena)
  );

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    csum_d  = csum_q;
    waddr_d = waddr_q;
    pk_clr  = 1'b0;
    pk_stb  = 1'b0;
    case (state_q)
      ST_CNT_LO: if (accept) begin
        n_d[7:0] = byte_data;
        state_d  = ST_CNT_HI;
      end
      ST_CNT_HI: if (accept) begin
        n_d    = n_full;
        idx_d  = '0;
        csum_d = '0;
        pk_clr = 1'b1;
        if (n_full > DEPTH_N)      state_d = ST_ERROR;
        else if (n_full == '0)     state_d = ST_CHECK;
        else                       state_d = ST_DATA;
      end
      ST_DATA: if (accept) begin
        pk_stb = 1'b1;
        csum_d = csum_q ^ byte_data;
        if (pk_last) begin
          // Address is captured alongside the word so both appear together next cycle.
          waddr_d = idx_q[ADDR_W-1:0];
          idx_d   = idx_inc;
          if (CNT_W'(idx_inc) == n_q) state_d = ST_CHECK;
        end
      end
      ST_CHECK: if (accept) begin
        state_d = (byte_data == csum_q) ? ST_DONE : ST_ERROR;
      end
      ST_DONE, ST_ERROR: if (reload) begin
        state_d = ST_CNT_LO;
        n_d     = '0;
        idx_d   = '0;
        csum_d  = '0;
        pk_clr  = 1'b1;
      end
      default: state_d = ST_CNT_LO;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_CNT_LO;
      n_q          <= '0;
      idx_q        <= '0;
      csum_q       <= '0;
      waddr_q      <= '0;
      byte_ready_q <= 1'b0;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
      core_rst_n_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      idx_q        <= idx_d;
      csum_q       <= csum_d;
      waddr_q      <= waddr_d;
      byte_ready_q <= (state_d != ST_DONE) && (state_d != ST_ERROR);
      load_done_q  <= (state_d == ST_DONE);
      load_err_q   <= (state_d == ST_ERROR);
      core_rst_n_q <= (state_d == ST_DONE);
    end
  end

  assign byte_ready = byte_ready_q;
  assign imem_waddr = waddr_q;
  assign load_done  = load_done_q;
  assign load_err   = load_err_q;
  assign core_rst_n = core_rst_n_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: hand-computed streams, write log captured from the memory port.
module tb_imem_loader;

  logic        clk;
  logic        rst;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        reload;
  logic        imem_wena;
  logic [5:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic        core_rst_n;
  logic        load_done;
  logic        load_err;

  int n_checks = 0;
  int n_pass   = 0;

  logic [5:0]  wr_addr [256];
  logic [31:0] wr_data [256];
  int          wr_total = 0;
  int          base;

  imem_loader #(.DEPTH(64), .ADDR_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .reload     (reload),
    .imem_wena  (imem_wena),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .core_rst_n (core_rst_n),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (imem_wena === 1'b1 && wr_total < 256) begin
      wr_addr[wr_total] = imem_waddr;
      wr_data[wr_total] = imem_wdata;
      wr_total++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    byte_valid = 1'b0;
    byte_data  = 8'hFF;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
  endtask

  task automatic send_two_word_prog(input logic [7:0] csum);
    logic [7:0] s [10];
    s = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00};
    for (int i = 0; i < 10; i++) send_byte(s[i]);
    send_byte(csum);
  endtask

  initial begin
    rst        = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    reload     = 1'b0;
    #12;
    chk("rst_byte_ready", 32'(byte_ready), 32'd0);
    chk("rst_wena",       32'(imem_wena),  32'd0);
    chk("rst_waddr",      32'(imem_waddr), 32'd0);
    chk("rst_wdata",      imem_wdata,      32'd0);
    chk("rst_core_rst_n", 32'(core_rst_n), 32'd0);
    chk("rst_done",       32'(load_done),  32'd0);
    chk("rst_err",        32'(load_err),   32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_rst", 32'(byte_ready), 32'd1);

    // Two-word program; XOR of the eight instruction bytes is 0x71.
    base = wr_total;
    send_two_word_prog(8'h71);
    chk("p2_done",       32'(load_done),  32'd1);
    chk("p2_core_rst_n", 32'(core_rst_n), 32'd1);
    chk("p2_err",        32'(load_err),   32'd0);
    chk("p2_ready",      32'(byte_ready), 32'd0);
    chk("p2_nwrites",    32'(wr_total - base), 32'd2);
    chk("p2_addr0",      32'(wr_addr[base]),   32'd0);
    chk("p2_data0",      wr_data[base],        32'h0050_0093);
    chk("p2_addr1",      32'(wr_addr[base+1]), 32'd1);
    chk("p2_data1",      wr_data[base+1],      32'h00A0_0113);

    // Reload from DONE, then one word 0xDEADBEEF (checksum 0x22).
    pulse_reload();
    chk("rl_core_rst_n", 32'(core_rst_n), 32'd0);
    chk("rl_done",       32'(load_done),  32'd0);
    chk("rl_ready",      32'(byte_ready), 32'd1);
    base = wr_total;
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
    chk("rl_wena_latency", 32'(imem_wena), 32'd1);
    send_byte(8'h22);
    chk("rl_nwrites", 32'(wr_total - base), 32'd1);
    chk("rl_addr0",   32'(wr_addr[base]),   32'd0);
    chk("rl_data0",   wr_data[base],        32'hDEAD_BEEF);
    chk("rl_done2",   32'(load_done),  32'd1);
    chk("rl_core_on", 32'(core_rst_n), 32'd1);

    // Bad checksum: both words still written, then sticky error.
    pulse_reload();
    base = wr_total;
    send_two_word_prog(8'h70);
    chk("bad_nwrites",    32'(wr_total - base), 32'd2);
    chk("bad_err",        32'(load_err),   32'd1);
    chk("bad_done",       32'(load_done),  32'd0);
    chk("bad_core_rst_n", 32'(core_rst_n), 32'd0);
    chk("bad_ready",      32'(byte_ready), 32'd0);
    send_byte(8'h71);
    idle_cycle();
    chk("bad_sticky",     32'(load_err),   32'd1);

    // Empty program.
    pulse_reload();
    chk("rl_err_clear", 32'(load_err), 32'd0);
    base = wr_total;
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    idle_cycle();
    chk("n0_nwrites", 32'(wr_total - base), 32'd0);
    chk("n0_done",    32'(load_done), 32'd1);

    // Oversize count, DEPTH+1.
    pulse_reload();
    base = wr_total;
    send_byte(8'h41);
    send_byte(8'h00);
    chk("big_err",   32'(load_err),  32'd1);
    chk("big_ready", 32'(byte_ready), 32'd0);
    idle_cycle();
    chk("big_nwrites", 32'(wr_total - base), 32'd0);

    // One word with byte_valid toggling; bytes 0xFF while invalid must be ignored.
    pulse_reload();
    base = wr_total;
    send_byte(8'h01); idle_cycle(); send_byte(8'h00); idle_cycle();
    send_byte(8'h11); idle_cycle(); send_byte(8'h22); idle_cycle();
    send_byte(8'h33); idle_cycle();
    chk("tg_no_early_wena", 32'(imem_wena), 32'd0);
    send_byte(8'h44);
    chk("tg_wena",  32'(imem_wena),  32'd1);
    chk("tg_waddr", 32'(imem_waddr), 32'd0);
    chk("tg_wdata", imem_wdata,      32'h4433_2211);
    idle_cycle();
    chk("tg_wena_pulse", 32'(imem_wena), 32'd0);
    send_byte(8'h44);
    chk("tg_done",    32'(load_done), 32'd1);
    chk("tg_nwrites", 32'(wr_total - base), 32'd1);

    // Asynchronous reset after five instruction bytes of a two-word load.
    pulse_reload();
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h05);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_ready",      32'(byte_ready), 32'd0);
    chk("ar_core_rst_n", 32'(core_rst_n), 32'd0);
    chk("ar_wena",       32'(imem_wena),  32'd0);
    chk("ar_waddr",      32'(imem_waddr), 32'd0);
    chk("ar_wdata",      imem_wdata,      32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    base = wr_total;
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    send_byte(8'h00);
    chk("ar_nwrites", 32'(wr_total - base), 32'd1);
    chk("ar_addr0",   32'(wr_addr[base]),   32'd0);
    chk("ar_data0",   wr_data[base],        32'hDDCC_BBAA);
    chk("ar_done",    32'(load_done), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
